// File: rtl/rx_frame_sr.sv
// Receive-frame shift register: collects DATA_BITS data, optional parity and STOP_BITS stop bits per frame.
// Latency: results and frame_done appear 2 cycles after the strobe cycle that carries the last stop bit.
// Backpressure: none; the upstream bit-timer paces every shift and the result holds until the next frame.
//
// Ports:
//   clk, rst                - rising-edge clock, synchronous active-high reset
//   frame_start/frame_abort - arm a new frame / discard the frame in progress
//   shift_strobe, serial_in - bit-centre sample pulse and the synchronised RX line
//   packet_data, stop_bit, parity_error, framing_error - last completed frame's result
//   frame_done              - one-cycle pulse when the result registers update
//   busy, bit_count         - frame-in-progress flag and bits captured so far
module rx_frame_sr #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 frame_abort,
    input  logic                 shift_strobe,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] packet_data,
    output logic                 stop_bit,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 frame_done,
    output logic                 busy,
    output logic [3:0]           bit_count
);

    localparam int         FRAME_BITS = DATA_BITS + PARITY_EN + STOP_BITS;
    localparam logic [3:0] LAST_BIT   = 4'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [FRAME_BITS-1:0] shreg;

    // Frame fields as they sit in a fully shifted register: first bit at index 0.
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_parity_err;
    logic                 rx_stop;

    assign rx_data       = shreg[DATA_BITS-1:0];
    // With parity disabled shreg[DATA_BITS] is a stop bit, so the term is masked off.
    assign rx_parity_err = (PARITY_EN != 0) ? (^rx_data ^ shreg[DATA_BITS] ^ 1'(PARITY_ODD))
                                            : 1'b0;
    assign rx_stop       = &shreg[FRAME_BITS-1 -: STOP_BITS];

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Abort outranks a coincident strobe, even on the final bit.
                if (frame_abort) begin
                    state_nxt = IDLE;
                end else if (shift_strobe && (bit_count == LAST_BIT - 4'd1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg         <= '1;
            bit_count     <= 4'd0;
            packet_data   <= '1;
            stop_bit      <= 1'b1;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A strobe alongside frame_start samples the start bit; it is not data.
                    if (frame_start) begin
                        bit_count <= 4'd0;
                        shreg     <= '1;
                    end
                end
                SHIFT: begin
                    if (frame_abort) begin
                        bit_count <= 4'd0;
                    end else if (shift_strobe && (bit_count < LAST_BIT)) begin
                        // LSB-first line order: new bits enter at the top and walk down.
                        shreg     <= {serial_in, shreg[FRAME_BITS-1:1]};
                        bit_count <= bit_count + 4'd1;
                    end
                end
                DONE: begin
                    packet_data   <= rx_data;
                    parity_error  <= rx_parity_err;
                    stop_bit      <= rx_stop;
                    framing_error <= ~rx_stop;
                    frame_done    <= 1'b1;
                    bit_count     <= 4'd0;
                end
                default: begin
                    bit_count <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_sr.sv
// Testbench for rx_frame_sr: four configurations (8N1, 8E1, 8O1, 5N2) share one stimulus bus.
// Each scenario targets one configuration and checks it against a frame-level reference model.
// Frames are built as bit vectors, first line bit at index 0.
module tb_rx_frame_sr;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_start = 1'b0;
    logic frame_abort = 1'b0;
    logic shift_strobe = 1'b0;
    logic serial_in = 1'b1;

    logic [7:0] pd0, pd1, pd2;
    logic [4:0] pd3;
    logic [3:0] sb_v, pe_v, fe_v, fd_v, bz_v;
    logic [3:0] bc_v [4];
    logic [8:0] pd_v [4];

    int total = 0;
    int bad   = 0;

    // Per-configuration settings, indexed like the DUT instances.
    int db_a [4] = '{8, 8, 8, 5};
    int pe_a [4] = '{0, 1, 1, 0};
    int po_a [4] = '{0, 0, 1, 0};
    int sb_a [4] = '{1, 1, 1, 2};
    logic [8:0] last_pd [4];

    assign pd_v[0] = {1'b0, pd0};
    assign pd_v[1] = {1'b0, pd1};
    assign pd_v[2] = {1'b0, pd2};
    assign pd_v[3] = {4'b0, pd3};

    always #5 clk = ~clk;

    rx_frame_sr #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_abort(frame_abort),
        .shift_strobe(shift_strobe), .serial_in(serial_in), .packet_data(pd0),
        .stop_bit(sb_v[0]), .parity_error(pe_v[0]), .framing_error(fe_v[0]),
        .frame_done(fd_v[0]), .busy(bz_v[0]), .bit_count(bc_v[0]));

    rx_frame_sr #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_abort(frame_abort),
        .shift_strobe(shift_strobe), .serial_in(serial_in), .packet_data(pd1),
        .stop_bit(sb_v[1]), .parity_error(pe_v[1]), .framing_error(fe_v[1]),
        .frame_done(fd_v[1]), .busy(bz_v[1]), .bit_count(bc_v[1]));

    rx_frame_sr #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_abort(frame_abort),
        .shift_strobe(shift_strobe), .serial_in(serial_in), .packet_data(pd2),
        .stop_bit(sb_v[2]), .parity_error(pe_v[2]), .framing_error(fe_v[2]),
        .frame_done(fd_v[2]), .busy(bz_v[2]), .bit_count(bc_v[2]));

    rx_frame_sr #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_5n2 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_abort(frame_abort),
        .shift_strobe(shift_strobe), .serial_in(serial_in), .packet_data(pd3),
        .stop_bit(sb_v[3]), .parity_error(pe_v[3]), .framing_error(fe_v[3]),
        .frame_done(fd_v[3]), .busy(bz_v[3]), .bit_count(bc_v[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] ones_mask(input int c);
        return 9'((1 << db_a[c]) - 1);
    endfunction

    // Line-order frame image: data, then parity (if enabled), then stop bits.
    function automatic logic [11:0] mk(input int c, input int data, input int par, input int stops);
        int v;
        v = data;
        if (pe_a[c] != 0) v = v | (par << db_a[c]);
        v = v | (stops << (db_a[c] + pe_a[c]));
        return 12'(v);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        frame_abort = 1'b0;
        shift_strobe = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) last_pd[i] = ones_mask(i);
    endtask

    // Drives one full frame into configuration c and checks the result against the model.
    task automatic run_frame(input int c, input logic [11:0] bits, input bit gaps);
        int n;
        int ones;
        logic [8:0] ed;
        logic ep;
        logic es;
        n = db_a[c] + pe_a[c] + sb_a[c];
        ed = '0;
        ones = 0;
        for (int i = 0; i < db_a[c]; i++) begin
            ed[i] = bits[i];
            ones += int'(bits[i]);
        end
        ep = (pe_a[c] != 0) ? (((ones + int'(bits[db_a[c]]) + po_a[c]) % 2) != 0) : 1'b0;
        es = 1'b1;
        for (int i = db_a[c] + pe_a[c]; i < n; i++) if (!bits[i]) es = 1'b0;

        frame_start = 1'b1;
        shift_strobe = 1'($urandom_range(0, 1));
        serial_in = 1'b0;
        tick();
        frame_start = 1'b0;
        shift_strobe = 1'b0;
        for (int i = 0; i < n; i++) begin
            serial_in = bits[i];
            shift_strobe = 1'b1;
            tick();
            shift_strobe = 1'b0;
            if (i == n - 2) begin
                total++;
                if (bc_v[c] !== 4'(n - 1) || bz_v[c] !== 1'b1) begin
                    bad++;
                    $display("FAIL bit_count_mid cfg%0d: got cnt=%0d busy=%b want cnt=%0d busy=1",
                             c, bc_v[c], bz_v[c], n - 1);
                end
            end
            if (gaps && i < n - 1) begin
                repeat ($urandom_range(0, 2)) begin
                    serial_in = 1'($urandom);
                    tick();
                end
            end
        end
        // DONE cycle: no pulse yet, previous result still held.
        total++;
        if (fd_v[c] !== 1'b0 || pd_v[c] !== last_pd[c] || bz_v[c] !== 1'b1) begin
            bad++;
            $display("FAIL done_cycle cfg%0d: got fd=%b pd=%h busy=%b want fd=0 pd=%h busy=1",
                     c, fd_v[c], pd_v[c], bz_v[c], last_pd[c]);
        end
        tick();
        total++;
        if (fd_v[c] !== 1'b1) begin
            bad++;
            $display("FAIL frame_done cfg%0d: got %b want 1", c, fd_v[c]);
        end
        total++;
        if (pd_v[c] !== ed) begin
            bad++;
            $display("FAIL packet_data cfg%0d: got %h want %h", c, pd_v[c], ed);
        end
        total++;
        if (sb_v[c] !== es || fe_v[c] !== ~es) begin
            bad++;
            $display("FAIL stop_framing cfg%0d: got stop=%b ferr=%b want stop=%b ferr=%b",
                     c, sb_v[c], fe_v[c], es, ~es);
        end
        total++;
        if (pe_v[c] !== ep) begin
            bad++;
            $display("FAIL parity_error cfg%0d: got %b want %b", c, pe_v[c], ep);
        end
        tick();
        total++;
        if (fd_v[c] !== 1'b0 || bz_v[c] !== 1'b0 || bc_v[c] !== 4'd0 || pd_v[c] !== ed) begin
            bad++;
            $display("FAIL after_done cfg%0d: got fd=%b busy=%b cnt=%0d pd=%h want 0 0 0 %h",
                     c, fd_v[c], bz_v[c], bc_v[c], pd_v[c], ed);
        end
        last_pd[c] = ed;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pd_v[i] !== ones_mask(i) || sb_v[i] !== 1'b1 || pe_v[i] !== 1'b0 ||
                fe_v[i] !== 1'b0 || bz_v[i] !== 1'b0 || bc_v[i] !== 4'd0 || fd_v[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset cfg%0d: got pd=%h sb=%b pe=%b fe=%b busy=%b cnt=%0d fd=%b want pd=%h 1 0 0 0 0 0",
                         i, pd_v[i], sb_v[i], pe_v[i], fe_v[i], bz_v[i], bc_v[i], fd_v[i], ones_mask(i));
            end
        end
    endtask

    task automatic test_directed();
        do_reset();
        run_frame(0, 12'h1A5, 1'b0);
        run_frame(0, mk(0, 'h3C, 0, 0), 1'b0);
        do_reset();
        run_frame(1, mk(1, 'h07, 1, 1), 1'b0);
        run_frame(1, mk(1, 'h07, 0, 1), 1'b0);
        do_reset();
        run_frame(2, mk(2, 'h07, 0, 1), 1'b0);
        do_reset();
        run_frame(3, mk(3, 'h15, 0, 1), 1'b0);
    endtask

    task automatic test_abort();
        do_reset();
        run_frame(0, 12'h1A5, 1'b0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            serial_in = 1'($urandom);
            shift_strobe = 1'b1;
            tick();
        end
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        shift_strobe = 1'b0;
        total++;
        if (bz_v[0] !== 1'b0 || bc_v[0] !== 4'd0 || fd_v[0] !== 1'b0 || pd_v[0] !== 9'h0A5) begin
            bad++;
            $display("FAIL abort: got busy=%b cnt=%0d fd=%b pd=%h want 0 0 0 0a5",
                     bz_v[0], bc_v[0], fd_v[0], pd_v[0]);
        end
        tick();
        total++;
        if (fd_v[0] !== 1'b0 || pd_v[0] !== 9'h0A5) begin
            bad++;
            $display("FAIL abort_hold: got fd=%b pd=%h want 0 0a5", fd_v[0], pd_v[0]);
        end
        run_frame(0, mk(0, 'h5A, 0, 1), 1'b1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_frame(0, mk(0, 'hC3, 0, 1), 1'b0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            serial_in = 1'($urandom);
            shift_strobe = 1'b1;
            tick();
        end
        shift_strobe = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_pd[0] = ones_mask(0);
        total++;
        if (pd_v[0] !== 9'h0FF || sb_v[0] !== 1'b1 || pe_v[0] !== 1'b0 || fe_v[0] !== 1'b0 ||
            bz_v[0] !== 1'b0 || bc_v[0] !== 4'd0 || fd_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got pd=%h sb=%b pe=%b fe=%b busy=%b cnt=%0d fd=%b want 0ff 1 0 0 0 0 0",
                     pd_v[0], sb_v[0], pe_v[0], fe_v[0], bz_v[0], bc_v[0], fd_v[0]);
        end
        for (int i = 0; i < 3; i++) begin
            serial_in = 1'($urandom);
            shift_strobe = 1'b1;
            tick();
        end
        shift_strobe = 1'b0;
        total++;
        if (bz_v[0] !== 1'b0 || bc_v[0] !== 4'd0 || fd_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL stray_strobe: got busy=%b cnt=%0d fd=%b want 0 0 0",
                     bz_v[0], bc_v[0], fd_v[0]);
        end
        run_frame(0, mk(0, 'h3C, 0, 0), 1'b1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 4; c++) begin
            do_reset();
            for (int k = 0; k < 15; k++) begin
                run_frame(c, 12'($urandom), 1'b1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
